ibex_register_file_ff_checker: RTL and testbench
================================================

Name: ibex_register_file_ff_checker

Overview:
- Response checker sitting directly downstream of the flip-flop register file in the RF test bench.
- Snoops the same write-port and read-address stimulus that drives the RF, plus the RF's two read-data outputs.
- Keeps a cycle-accurate shadow copy of the register contents and compares every qualified read against it.
- Reports pass/fail, a mismatch count, a check count and the first failing access.

Parameters:
- RV32E, 0, when 1 only x0..x15 exist; reads with addr[4]=1 are not checked and writes with waddr[4]=1 do not update the shadow.
- DataWidth, 32, register and data width in bits.
- WordZeroVal, '0, reset value of every register and the permanent value of x0.
- ErrCntWidth, 16, width of the mismatch counter (saturating).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse: clear statistics and enter RUN.
- stop_i  in  1  pulse: end checking and enter DONE.
- rvalid_i  in  1  read addresses and data are valid this cycle; check them.
- raddr_a_i  in  5  read port A address.
- rdata_a_i  in  DataWidth  RF read port A data.
- raddr_b_i  in  5  read port B address.
- rdata_b_i  in  DataWidth  RF read port B data.
- waddr_a_i  in  5  write address.
- wdata_a_i  in  DataWidth  write data.
- we_a_i  in  1  write enable.
- busy_o  out  1  FSM is in RUN.
- done_o  out  1  FSM is in DONE.
- pass_o  out  1  DONE and err_cnt_o==0.
- err_cnt_o  out  ErrCntWidth  mismatch count.
- chk_cnt_o  out  32  number of individual port checks performed.
- fail_valid_o  out  1  first-failure record is populated.
- fail_port_o  out  1  failing port: 0=A, 1=B.
- fail_addr_o  out  5  address of the first failing read.
- fail_exp_o  out  DataWidth  expected data of the first failing read.
- fail_got_o  out  DataWidth  observed data of the first failing read.

Behaviour:
- Reset (async assert; release is sampled on clk_i):
  - State goes to IDLE.
  - All shadow entries are set to WordZeroVal.
  - Every output is 0, except fail_exp_o/fail_got_o, which are also 0.
- Shadow update: on every edge in any state, if we_a_i && waddr_a_i!=0 (and not RV32E with waddr_a_i[4]), shadow[waddr_a_i] <= wdata_a_i. x0 is never written.
- Expected value for a read:
  - WordZeroVal for address 0.
  - Otherwise the shadow value before this cycle's write. The RF read path is combinational and the RF write lands at the edge, so read-during-write to the same address expects the old data.
- States and transitions:
  - IDLE -> RUN on start_i.
  - RUN -> DONE on stop_i. stop_i has priority if start_i and stop_i are asserted together in RUN.
  - DONE -> RUN on start_i.
  - start_i has no effect in RUN; stop_i has no effect in IDLE or DONE.
  - Entering RUN clears err_cnt_o, chk_cnt_o, fail_valid_o and fail_port_o/addr/exp/got. The shadow is not cleared.
- Checking:
  - Only in RUN with rvalid_i=1; this includes the cycle stop_i is asserted.
  - Ports A and B are checked independently.
  - Each checked port increments chk_cnt_o (by 0, 1 or 2 per cycle; wraps modulo 2^32).
  - Each mismatch increments err_cnt_o, saturating at all-ones.
- Status latency: err_cnt_o, chk_cnt_o and the fail_* outputs update one cycle after the checked read.
- First-failure capture: latched only while fail_valid_o=0. If both ports fail in the same cycle, port A is recorded.
- Status outputs: busy_o, done_o and pass_o are registered state decodes. pass_o is high only in DONE with zero errors.

Optional Feature:
- Macro: RF_CHK_HALT_ON_FAIL_EN.
- Defined:
  - The first mismatch forces RUN -> DONE on the next edge.
  - No further checks are performed and err_cnt_o stays at 1 (or 2 if both ports failed in that cycle).
- Undefined: checking continues until stop_i; behaviour is exactly as above.

Test Plan:
- Reset, then start_i; read x0..x31 on both ports, with rdata equal to WordZeroVal (0), for 32 cycles; then stop_i -> chk_cnt_o=64, err_cnt_o=0, pass_o=1, done_o=1.
- Write x5=32'hDEADBEEF; next cycle read A=x5 with rdata_a_i=32'hDEADBEEF -> no error. Same-cycle write x6=32'h1234 with read B=x6 and rdata_b_i=0 -> no error.
- Write x0=32'hFFFFFFFF, then read x0 returning 32'hFFFFFFFF -> err_cnt_o=1, fail_addr_o=0, fail_exp_o=0, fail_got_o=32'hFFFFFFFF, fail_port_o=0.
- Both ports mismatch in the same cycle (A=x3, B=x4) -> err_cnt_o=2, fail_port_o=0, fail_addr_o=3. A later mismatch on x9 leaves the fail_* record unchanged.
- RV32E=1: read x20 returning garbage -> chk_cnt_o unchanged, no error. Write x20 -> shadow unchanged.
- Assert rst_i mid-RUN after x7 was written -> all outputs 0, state IDLE. After start_i, read x7 with rdata 0 -> no error.
- With RF_CHK_HALT_ON_FAIL_EN defined: one mismatch -> next cycle done_o=1, busy_o=0. Further mismatching reads leave err_cnt_o=1.

Source files
------------

// File: rtl/ibex_register_file_ff_checker.sv
// ---------------------------------------------------------------------------
// ibex_register_file_ff_checker
//
// Response checker for the flip-flop register file. It snoops the RF write
// port and read addresses, keeps a cycle-accurate shadow of the registers and
// compares both RF read-data outputs against it while in RUN.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i / stop_i        pulses: clear statistics and enter RUN / enter DONE
//   rvalid_i                read ports carry a valid access this cycle
//   raddr_a_i, rdata_a_i    read port A address and RF data
//   raddr_b_i, rdata_b_i    read port B address and RF data
//   waddr_a_i, wdata_a_i,
//   we_a_i                  RF write port
//   busy_o, done_o, pass_o  state decodes (pass = DONE with no mismatches)
//   err_cnt_o               saturating mismatch count
//   chk_cnt_o               number of individual port checks (wraps)
//   fail_*_o                record of the first failing access
//
// Optional feature (macro RF_CHK_HALT_ON_FAIL_EN): the first mismatch forces
// RUN -> DONE on the next edge so no further checks are made.
//
// States:
//   IDLE | out of reset, no checking
//   RUN  | checking qualified reads
//   DONE | checking finished, results held
// ---------------------------------------------------------------------------
module ibex_register_file_ff_checker #(
  parameter bit                    RV32E       = 1'b0,
  parameter int unsigned           DataWidth   = 32,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0,
  parameter int unsigned           ErrCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   rvalid_i,
  input  logic [4:0]             raddr_a_i,
  input  logic [DataWidth-1:0]   rdata_a_i,
  input  logic [4:0]             raddr_b_i,
  input  logic [DataWidth-1:0]   rdata_b_i,
  input  logic [4:0]             waddr_a_i,
  input  logic [DataWidth-1:0]   wdata_a_i,
  input  logic                   we_a_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [31:0]            chk_cnt_o,
  output logic                   fail_valid_o,
  output logic                   fail_port_o,
  output logic [4:0]             fail_addr_o,
  output logic [DataWidth-1:0]   fail_exp_o,
  output logic [DataWidth-1:0]   fail_got_o
);

  localparam int unsigned ErrSumWidth = ErrCntWidth + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DataWidth-1:0]   shadow_q [32];

  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]            chk_cnt_q, chk_cnt_d;
  logic                   fail_valid_q, fail_valid_d;
  logic                   fail_port_q, fail_port_d;
  logic [4:0]             fail_addr_q, fail_addr_d;
  logic [DataWidth-1:0]   fail_exp_q, fail_exp_d;
  logic [DataWidth-1:0]   fail_got_q, fail_got_d;

  logic                   wr_en;
  logic                   chk_a, chk_b;
  logic                   mis_a, mis_b;
  logic [DataWidth-1:0]   exp_a, exp_b;
  logic                   clear_stats;
  logic [ErrSumWidth-1:0] err_sum;

  // ---------------------------------------------------------------------------
  // Shadow register file. Writes track the RF in every state; x0 is never
  // written and, for RV32E, the upper half of the address space does not exist.
  // ---------------------------------------------------------------------------
  assign wr_en = we_a_i && (waddr_a_i != 5'd0) && !(RV32E && waddr_a_i[4]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= WordZeroVal;
      end
    end else if (wr_en) begin
      shadow_q[waddr_a_i] <= wdata_a_i;
    end
  end

  // Shadow is read before this edge's write lands, matching the RF's
  // combinational read path (read-during-write returns old data).
  assign exp_a = (raddr_a_i == 5'd0) ? WordZeroVal : shadow_q[raddr_a_i];
  assign exp_b = (raddr_b_i == 5'd0) ? WordZeroVal : shadow_q[raddr_b_i];

  assign chk_a = (state_q == RUN) && rvalid_i && !(RV32E && raddr_a_i[4]);
  assign chk_b = (state_q == RUN) && rvalid_i && !(RV32E && raddr_b_i[4]);
  assign mis_a = chk_a && (rdata_a_i != exp_a);
  assign mis_b = chk_b && (rdata_b_i != exp_b);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_stats = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = RUN;
          clear_stats = 1'b1;
        end
      end
      RUN: begin
`ifdef RF_CHK_HALT_ON_FAIL_EN
        if (stop_i || mis_a || mis_b) begin
          state_d = DONE;
        end
`else
        if (stop_i) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (start_i) begin
          state_d     = RUN;
          clear_stats = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics and first-failure record. Clearing only happens on entry to RUN,
  // where no check can be active, so the two branches never overlap.
  // ---------------------------------------------------------------------------
  assign err_sum = {1'b0, err_cnt_q} + ErrSumWidth'(mis_a) + ErrSumWidth'(mis_b);

  always_comb begin
    err_cnt_d    = err_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_port_d  = fail_port_q;
    fail_addr_d  = fail_addr_q;
    fail_exp_d   = fail_exp_q;
    fail_got_d   = fail_got_q;
    if (clear_stats) begin
      err_cnt_d    = '0;
      chk_cnt_d    = '0;
      fail_valid_d = 1'b0;
      fail_port_d  = 1'b0;
      fail_addr_d  = '0;
      fail_exp_d   = '0;
      fail_got_d   = '0;
    end else begin
      chk_cnt_d = chk_cnt_q + 32'(chk_a) + 32'(chk_b);
      err_cnt_d = err_sum[ErrCntWidth] ? '1 : err_sum[ErrCntWidth-1:0];
      if (!fail_valid_q && (mis_a || mis_b)) begin
        fail_valid_d = 1'b1;
        // Port A wins when both ports fail together.
        if (mis_a) begin
          fail_port_d = 1'b0;
          fail_addr_d = raddr_a_i;
          fail_exp_d  = exp_a;
          fail_got_d  = rdata_a_i;
        end else begin
          fail_port_d = 1'b1;
          fail_addr_d = raddr_b_i;
          fail_exp_d  = exp_b;
          fail_got_d  = rdata_b_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q    <= '0;
      chk_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_port_q  <= 1'b0;
      fail_addr_q  <= '0;
      fail_exp_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_port_q  <= fail_port_d;
      fail_addr_q  <= fail_addr_d;
      fail_exp_q   <= fail_exp_d;
      fail_got_q   <= fail_got_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign pass_o       = (state_q == DONE) && (err_cnt_q == '0);
  assign err_cnt_o    = err_cnt_q;
  assign chk_cnt_o    = chk_cnt_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_port_o  = fail_port_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_exp_o   = fail_exp_q;
  assign fail_got_o   = fail_got_q;

endmodule

// File: tb/tb_ibex_register_file_ff_checker.sv
// ---------------------------------------------------------------------------
// Directed bench for ibex_register_file_ff_checker. Two instances share the
// stimulus: u_dut (RV32I) and u_dut_e (RV32E). Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ibex_register_file_ff_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stop_i, rvalid_i, we_a_i;
  logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
  logic [31:0] rdata_a_i, rdata_b_i, wdata_a_i;

  logic        busy_o, done_o, pass_o, fail_valid_o, fail_port_o;
  logic [15:0] err_cnt_o;
  logic [31:0] chk_cnt_o, fail_exp_o, fail_got_o;
  logic [4:0]  fail_addr_o;

  logic        busy_e, done_e, pass_e, fail_valid_e, fail_port_e;
  logic [15:0] err_cnt_e;
  logic [31:0] chk_cnt_e, fail_exp_e, fail_got_e;
  logic [4:0]  fail_addr_e;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_register_file_ff_checker u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .rvalid_i(rvalid_i), .raddr_a_i(raddr_a_i), .rdata_a_i(rdata_a_i),
    .raddr_b_i(raddr_b_i), .rdata_b_i(rdata_b_i), .waddr_a_i(waddr_a_i),
    .wdata_a_i(wdata_a_i), .we_a_i(we_a_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_cnt_o(err_cnt_o), .chk_cnt_o(chk_cnt_o),
    .fail_valid_o(fail_valid_o), .fail_port_o(fail_port_o),
    .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o), .fail_got_o(fail_got_o)
  );

  ibex_register_file_ff_checker #(.RV32E(1'b1)) u_dut_e (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .rvalid_i(rvalid_i), .raddr_a_i(raddr_a_i), .rdata_a_i(rdata_a_i),
    .raddr_b_i(raddr_b_i), .rdata_b_i(rdata_b_i), .waddr_a_i(waddr_a_i),
    .wdata_a_i(wdata_a_i), .we_a_i(we_a_i), .busy_o(busy_e), .done_o(done_e),
    .pass_o(pass_e), .err_cnt_o(err_cnt_e), .chk_cnt_o(chk_cnt_e),
    .fail_valid_o(fail_valid_e), .fail_port_o(fail_port_e),
    .fail_addr_o(fail_addr_e), .fail_exp_o(fail_exp_e), .fail_got_o(fail_got_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    start_i = 1'b0; stop_i = 1'b0; rvalid_i = 1'b0; we_a_i = 1'b0;
    raddr_a_i = '0; raddr_b_i = '0; waddr_a_i = '0;
    rdata_a_i = '0; rdata_b_i = '0; wdata_a_i = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we_a_i = 1'b1; waddr_a_i = a; wdata_a_i = d;
    tick();
    clear_in();
  endtask

  task automatic do_read(input logic [4:0] aa, input logic [31:0] da,
                         input logic [4:0] ab, input logic [31:0] db);
    rvalid_i = 1'b1;
    raddr_a_i = aa; rdata_a_i = da;
    raddr_b_i = ab; rdata_b_i = db;
    tick();
    clear_in();
  endtask

  // From RUN or DONE: end up in RUN with cleared statistics.
  task automatic restart();
    stop_i = 1'b1;
    tick();
    clear_in();
    start_i = 1'b1;
    tick();
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    rst_i = 1'b1;
    tick();
    tick();
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_pass",  32'(pass_o), 32'd0);
    check("rst_err",   32'(err_cnt_o), 32'd0);
    check("rst_chk",   chk_cnt_o, 32'd0);
    check("rst_fval",  32'(fail_valid_o), 32'd0);
    check("rst_fexp",  fail_exp_o, 32'd0);
    check("rst_fgot",  fail_got_o, 32'd0);
    rst_i = 1'b0;

    // Sweep every register on both ports, all zero.
    start_i = 1'b1;
    tick();
    clear_in();
    check("start_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 32'd0, 5'(31 - i), 32'd0);
    end
    check("sweep_chk",   chk_cnt_o, 32'd64);
    check("sweep_chk_e", chk_cnt_e, 32'd32);
    check("sweep_err",   32'(err_cnt_o), 32'd0);
    stop_i = 1'b1;
    tick();
    clear_in();
    check("sweep_done", 32'(done_o), 32'd1);
    check("sweep_busy", 32'(busy_o), 32'd0);
    check("sweep_pass", 32'(pass_o), 32'd1);
    check("sweep_chk2", chk_cnt_o, 32'd64);

    // DONE -> RUN clears stats; write then read, and read-during-write.
    start_i = 1'b1;
    tick();
    clear_in();
    check("rerun_chk",  chk_cnt_o, 32'd0);
    check("rerun_busy", 32'(busy_o), 32'd1);
    do_write(5'd5, 32'hDEADBEEF);
    we_a_i = 1'b1; waddr_a_i = 5'd6; wdata_a_i = 32'h1234;
    do_read(5'd5, 32'hDEADBEEF, 5'd6, 32'd0);
    check("rdw_err", 32'(err_cnt_o), 32'd0);
    check("rdw_chk", chk_cnt_o, 32'd2);
    do_read(5'd0, 32'd0, 5'd6, 32'h1234);
    check("x6_err", 32'(err_cnt_o), 32'd0);
    check("x6_chk", chk_cnt_o, 32'd4);

    // x0 is never written.
    do_write(5'd0, 32'hFFFFFFFF);
    do_read(5'd0, 32'hFFFFFFFF, 5'd5, 32'hDEADBEEF);
    check("x0_err",   32'(err_cnt_o), 32'd1);
    check("x0_chk",   chk_cnt_o, 32'd6);
    check("x0_fval",  32'(fail_valid_o), 32'd1);
    check("x0_fport", 32'(fail_port_o), 32'd0);
    check("x0_faddr", 32'(fail_addr_o), 32'd0);
    check("x0_fexp",  fail_exp_o, 32'd0);
    check("x0_fgot",  fail_got_o, 32'hFFFFFFFF);

    // Both ports fail together: port A recorded.
    restart();
    check("both_clr_fval", 32'(fail_valid_o), 32'd0);
    do_write(5'd3, 32'h33);
    do_write(5'd4, 32'h44);
    do_read(5'd3, 32'd0, 5'd4, 32'd0);
    check("both_err",   32'(err_cnt_o), 32'd2);
    check("both_chk",   chk_cnt_o, 32'd2);
    check("both_fport", 32'(fail_port_o), 32'd0);
    check("both_faddr", 32'(fail_addr_o), 32'd3);
    check("both_fexp",  fail_exp_o, 32'h33);
    check("both_fgot",  fail_got_o, 32'd0);
`ifdef RF_CHK_HALT_ON_FAIL_EN
    check("halt_done", 32'(done_o), 32'd1);
    check("halt_busy", 32'(busy_o), 32'd0);
    do_read(5'd9, 32'd1, 5'd0, 32'd0);
    check("halt_err", 32'(err_cnt_o), 32'd2);
    check("halt_chk", chk_cnt_o, 32'd2);
`else
    do_read(5'd9, 32'd1, 5'd0, 32'd0);
    check("later_err",   32'(err_cnt_o), 32'd3);
    check("later_chk",   chk_cnt_o, 32'd4);
    check("later_faddr", 32'(fail_addr_o), 32'd3);
    check("later_fexp",  fail_exp_o, 32'h33);
    check("later_fport", 32'(fail_port_o), 32'd0);
`endif

    // Port B alone fails.
    restart();
    do_read(5'd0, 32'd0, 5'd3, 32'd0);
    check("b_err",   32'(err_cnt_o), 32'd1);
    check("b_fport", 32'(fail_port_o), 32'd1);
    check("b_faddr", 32'(fail_addr_o), 32'd3);
    check("b_fexp",  fail_exp_o, 32'h33);

    // RV32E: upper registers are neither checked nor written (no aliasing onto x4).
    restart();
    do_write(5'd20, 32'hAAAA);
    do_read(5'd20, 32'h55551234, 5'd4, 32'h44);
    check("e_chk",     chk_cnt_e, 32'd1);
    check("e_err",     32'(err_cnt_e), 32'd0);
    check("i_x20_chk", chk_cnt_o, 32'd2);
    check("i_x20_err", 32'(err_cnt_o), 32'd1);
    check("i_x20_fa",  32'(fail_addr_o), 32'd20);
    check("i_x20_fe",  fail_exp_o, 32'hAAAA);
    check("i_x20_fg",  fail_got_o, 32'h55551234);

    // Asynchronous reset mid-RUN clears everything including the shadow.
    restart();
    do_write(5'd7, 32'h77);
    do_read(5'd7, 32'd0, 5'd0, 32'd0);
    check("pre_rst_err", 32'(err_cnt_o), 32'd1);
    rst_i = 1'b1;
    #2;
    check("arst_busy",  32'(busy_o), 32'd0);
    check("arst_done",  32'(done_o), 32'd0);
    check("arst_err",   32'(err_cnt_o), 32'd0);
    check("arst_chk",   chk_cnt_o, 32'd0);
    check("arst_fval",  32'(fail_valid_o), 32'd0);
    check("arst_faddr", 32'(fail_addr_o), 32'd0);
    check("arst_fexp",  fail_exp_o, 32'd0);
    check("arst_fgot",  fail_got_o, 32'd0);
    tick();
    rst_i = 1'b0;
    check("arst_idle_busy", 32'(busy_o), 32'd0);
    start_i = 1'b1;
    tick();
    clear_in();
    check("post_rst_busy", 32'(busy_o), 32'd1);
    do_read(5'd7, 32'd0, 5'd5, 32'd0);
    check("post_rst_err", 32'(err_cnt_o), 32'd0);
    check("post_rst_chk", chk_cnt_o, 32'd2);

    // stop wins over start in RUN; the stop cycle is still checked.
    restart();
    start_i = 1'b1; stop_i = 1'b1;
    do_read(5'd0, 32'd0, 5'd0, 32'd0);
    check("prio_done", 32'(done_o), 32'd1);
    check("prio_busy", 32'(busy_o), 32'd0);
    check("prio_chk",  chk_cnt_o, 32'd2);
    check("prio_pass", 32'(pass_o), 32'd1);

    // DONE with errors does not pass.
    restart();
    do_read(5'd1, 32'd1, 5'd0, 32'd0);
    stop_i = 1'b1;
    tick();
    clear_in();
    check("nopass_done", 32'(done_o), 32'd1);
    check("nopass_pass", 32'(pass_o), 32'd0);
    check("nopass_err",  32'(err_cnt_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
